// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and ramp helper for PWM-style drive blocks
package pwm_pkg;
    localparam int DEF_N_CH   = 2;
    localparam int DEF_CNT_W  = 8;
    localparam int MIN_PERIOD = 2;
    localparam int RAMP_W     = 32;

    // Moves cur toward tgt by at most step; step 0 jumps straight to tgt.
    function automatic logic [RAMP_W-1:0] ramp_toward(
        input logic [RAMP_W-1:0] cur,
        input logic [RAMP_W-1:0] tgt,
        input logic [RAMP_W-1:0] step
    );
        logic [RAMP_W-1:0] diff;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if (step == '0 || diff <= step) begin
            return tgt;
        end else if (tgt > cur) begin
            return cur + step;
        end else begin
            return cur - step;
        end
    endfunction
endpackage

// File: rtl/pwm_multi_gen_if.sv
// rtl/pwm_multi_gen_if.sv - set-point inputs and PWM outputs of pwm_multi_gen
interface pwm_multi_gen_if import pwm_pkg::*; #(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
);
    logic [N_CH-1:0]       en;
    logic [CNT_W-1:0]      period;
    logic [N_CH*CNT_W-1:0] duty_set;
    logic [N_CH-1:0]       pwm_out;
    logic                  period_end;
    logic [N_CH-1:0]       ramp_done;

    modport master (output en, period, duty_set, input pwm_out, period_end, ramp_done);
    modport slave  (input en, period, duty_set, output pwm_out, period_end, ramp_done);
endinterface

// File: rtl/pwm_ch_ramp.sv
// rtl/pwm_ch_ramp.sv - one PWM channel: period-boundary duty update with soft-start ramp
module pwm_ch_ramp import pwm_pkg::*; #(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RAMP_STEP = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_set_i,
    output logic             pwm_o,
    output logic             ramp_done_o
);
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] tgt;
    logic             pwm_q, ramp_done_q;

    // Target is clamped against the period in force now, so a period loaded at
    // this wrap only affects the clamp from the next wrap on.
    always_comb begin
        tgt    = (duty_set_i < period_i) ? duty_set_i : period_i;
        duty_d = duty_q;
        if (!en_i) begin
            duty_d = '0;
        end else if (wrap_i) begin
            duty_d = CNT_W'(ramp_toward(RAMP_W'(duty_q), RAMP_W'(tgt), RAMP_W'(RAMP_STEP)));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q      <= '0;
            pwm_q       <= 1'b0;
            ramp_done_q <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            pwm_q       <= en_i && (cnt_i < duty_q);
            ramp_done_q <= en_i && (duty_q == tgt);
        end
    end

    assign pwm_o       = pwm_q;
    assign ramp_done_o = ramp_done_q;
endmodule

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - N-channel PWM generator with shared programmable period counter
module pwm_multi_gen import pwm_pkg::*; #(
    parameter int N_CH       = DEF_N_CH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = 100,
    parameter int RAMP_STEP  = 5
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pwm_multi_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_end_q;
    logic             wrap;
    logic [N_CH-1:0]  pwm_w, done_w;

    // Period requests are only honoured at the wrap so a period is never cut short.
    always_comb begin
        wrap     = (cnt_q == (period_q - ONE));
        cnt_d    = wrap ? '0 : (cnt_q + ONE);
        period_d = period_q;
        if (wrap) begin
            period_d = (bus.period < MIN_P) ? MIN_P : bus.period;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            period_q     <= CNT_W'(DEF_PERIOD);
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_end_q <= wrap;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_ch_ramp #(
            .CNT_W     (CNT_W),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (bus.en[i]),
            .wrap_i      (wrap),
            .cnt_i       (cnt_q),
            .period_i    (period_q),
            .duty_set_i  (bus.duty_set[i*CNT_W +: CNT_W]),
            .pwm_o       (pwm_w[i]),
            .ramp_done_o (done_w[i])
        );
    end

    assign bus.pwm_out    = pwm_w;
    assign bus.ramp_done  = done_w;
    assign bus.period_end = period_end_q;
endmodule
